btn_conditioner: RTL and testbench

Input-conditioning stage between the raw button pins and the whack-a-mole top level. It feeds the game FSM clean, glitch-free button levels and single-cycle press/release pulses. Each of the `WIDTH` buttons passes through three steps in order:
- a multi-flop synchronizer;
- a per-button debounce counter;
- an edge detector.

The block replaces the direct use of the raw button bus ahead of the lockout mask.

---
 rtl/btn_conditioner.sv | 88 ++++++++
 tb/tb_btn_conditioner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Button input conditioning: per-bit synchronizer, debounce counter and edge detector.
// Produces clean debounced levels plus registered one-cycle press/release pulses.
module btn_conditioner #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic             any_press
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] db_q, db_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;

  // Synchronizer runs every cycle, independent of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= btn_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter clears whenever the synchronized level agrees with db or ena is low,
  // so any deviation shorter than DEBOUNCE_CYCLES is forgotten.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (ena && (s[i] != db_q[i])) begin
        if (cnt_q[i] == CntMax) begin
          db_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
    press_d   = db_d & ~db_q;
    release_d = db_q & ~db_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = db_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign any_press   = |press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): stimulus queues
// expected pulse events, a negedge monitor pops and compares whenever a pulse appears.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] btn_raw = '0;
  logic [7:0] btn_level, btn_press, btn_release;
  logic       any_press;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  typedef struct {
    int         cyc;
    logic [7:0] press;
    logic [7:0] rel;
    logic [7:0] level;
  } exp_t;

  exp_t q[$];

  btn_conditioner #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  task automatic push(int cyc, logic [7:0] p, logic [7:0] r, logic [7:0] l);
    exp_t e;
    e.cyc = cyc; e.press = p; e.rel = r; e.level = l;
    q.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse must match the head of the scoreboard; overdue entries are misses.
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < edge_n) begin
        chk("missed_event_at_edge", edge_n, q[0].cyc);
        void'(q.pop_front());
      end
      if (btn_press != 0 || btn_release != 0 || any_press) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {btn_press, btn_release}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("event_edge", edge_n, e.cyc);
          chk("btn_press", btn_press, e.press);
          chk("btn_release", btn_release, e.rel);
          chk("btn_level", btn_level, e.level);
          chk("any_press", any_press, int'(|e.press));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic bounce_on  [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    logic bounce_off [9] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
    int t0;

    // Reset with all raw buttons high.
    btn_raw = 8'hFF;
    #2 rst_n = 1'b0;
    tick(3);
    chk("reset_level", btn_level, 0);
    chk("reset_press", btn_press, 0);
    chk("reset_release", btn_release, 0);
    chk("reset_any", any_press, 0);
    rst_n = 1'b1;
    push(edge_n + 6, 8'hFF, 8'h00, 8'hFF);
    tick(10);
    btn_raw = 8'h00;
    push(edge_n + 6, 8'h00, 8'hFF, 8'h00);
    tick(10);

    // Clean press and release on bit 3.
    btn_raw[3] = 1'b1;
    push(edge_n + 6, 8'h08, 8'h00, 8'h08);
    tick(10);
    btn_raw[3] = 1'b0;
    push(edge_n + 6, 8'h00, 8'h08, 8'h00);
    tick(10);

    // Glitch of 3 cycles is rejected; 4 cycles is accepted.
    btn_raw[0] = 1'b1;
    tick(3);
    btn_raw[0] = 1'b0;
    tick(10);
    chk("glitch_level", btn_level, 0);
    btn_raw[0] = 1'b1;
    t0 = edge_n;
    tick(4);
    btn_raw[0] = 1'b0;
    push(t0 + 6, 8'h01, 8'h00, 8'h01);
    push(t0 + 10, 8'h00, 8'h01, 8'h00);
    tick(12);

    // Bounce on bit 5, both directions.
    t0 = edge_n;
    for (int k = 0; k < 9; k++) begin
      btn_raw[5] = bounce_on[k];
      tick(1);
    end
    push(t0 + 11, 8'h20, 8'h00, 8'h20);
    tick(6);
    t0 = edge_n;
    for (int k = 0; k < 9; k++) begin
      btn_raw[5] = bounce_off[k];
      tick(1);
    end
    push(t0 + 11, 8'h00, 8'h20, 8'h00);
    tick(8);

    // Simultaneous buttons.
    btn_raw = 8'h81;
    push(edge_n + 6, 8'h81, 8'h00, 8'h81);
    tick(10);
    btn_raw = 8'h00;
    push(edge_n + 6, 8'h00, 8'h81, 8'h00);
    tick(10);

    // Disabled during a 10-cycle pulse: nothing happens.
    ena = 1'b0;
    tick(1);
    btn_raw[2] = 1'b1;
    tick(10);
    btn_raw[2] = 1'b0;
    tick(5);
    ena = 1'b1;
    tick(10);
    chk("disabled_level", btn_level, 0);

    // Reset while bit 4 counter sits at 2: partial count discarded, no pulse.
    btn_raw[4] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    btn_raw[4] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("midreset_level", btn_level, 0);

    // Short re-press of bit 4 after reset must still need a full debounce.
    btn_raw[4] = 1'b1;
    tick(2);
    btn_raw[4] = 1'b0;
    tick(10);
    chk("post_reset_glitch_level", btn_level, 0);

    tick(5);
    while (q.size() > 0) begin
      chk("event_never_seen", edge_n, q[0].cyc);
      void'(q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
